reorder_buffer: RTL

//   In-order retirement for the out-of-order core; sits directly downstream of dispatch and upstream of

---
 rtl/rob_pkg.sv | 27 ++
 rtl/rob_rename_table.sv | 31 +++
 rtl/reorder_buffer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared tag width, entry layout and tag/index helpers for the reorder buffer
package rob_pkg;
   localparam int TAG_W = 5;
   localparam logic [TAG_W-1:0] NO_TAG = '0;
   typedef enum logic [1:0] {
      T_REG    = 2'd0,
      T_STORE  = 2'd1,
      T_BRANCH = 2'd2
   } rob_type_e;
   typedef struct packed {
      logic        busy;
      logic        ready;
      rob_type_e   kind;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        pred;
      logic [31:0] value;
      logic        taken;
      logic [31:0] target;
   } rob_entry_t;
   function automatic logic [TAG_W-1:0] idx_to_tag(input logic [TAG_W-1:0] idx);
      return idx + TAG_W'(1);
   endfunction
   function automatic logic [TAG_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag);
      return tag - TAG_W'(1);
   endfunction
endpackage

// File: rtl/rob_rename_table.sv
// rob_rename_table: per-arch-register tag of the youngest in-flight writer
module rob_rename_table
   import rob_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_all,
   input  logic             set_en,
   input  logic [4:0]       set_addr,
   input  logic [TAG_W-1:0] set_tag,
   input  logic             clr_en,
   input  logic [4:0]       clr_addr,
   input  logic [TAG_W-1:0] clr_tag,
   input  logic [4:0]       rd_addr,
   output logic [TAG_W-1:0] rd_tag
);
   logic [TAG_W-1:0] map_q [32];
   logic [TAG_W-1:0] map_d [32];
   // a same-cycle dispatch to the committing register must survive the match-clear
   always_comb begin
      map_d = map_q;
      if (clr_en && map_q[clr_addr] == clr_tag) map_d[clr_addr] = NO_TAG;
      if (set_en) map_d[set_addr] = set_tag;
      if (clr_all) map_d = '{default: NO_TAG};
   end
   always_ff @(posedge clk) begin
      if (rst) map_q <= '{default: NO_TAG};
      else map_q <= map_d;
   end
   assign rd_tag = map_q[rd_addr];
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: tag allocation, CDB capture and in-order retirement with mispredict flush
module reorder_buffer
   import rob_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              disp_valid,
   input  logic [1:0]        disp_type,
   input  logic [4:0]        disp_rd,
   input  logic [31:0]       disp_pc,
   input  logic              disp_pred_taken,
   output logic              disp_ready,
   output logic [TAG_W-1:0]  disp_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [31:0]       cdb_value,
   input  logic              cdb_taken,
   input  logic [31:0]       cdb_target,
   input  logic [TAG_W-1:0]  q_tag1,
   input  logic [TAG_W-1:0]  q_tag2,
   output logic              q_ready1,
   output logic              q_ready2,
   output logic [31:0]       q_value1,
   output logic [31:0]       q_value2,
   output logic              rf_write_enable,
   output logic [4:0]        rf_write_addr,
   output logic [36:0]       rf_write_data,
   output logic              store_commit,
   output logic              flush,
   output logic [31:0]       flush_pc
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   rob_entry_t ent_q [DEPTH];
   rob_entry_t ent_d [DEPTH];
   logic [IW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic flush_pend_q, flush_pend_d;
   logic we_q, we_d, store_q, store_d, flush_q, flush_d;
   logic [4:0] waddr_q, waddr_d;
   logic [36:0] wdata_q, wdata_d;
   logic [31:0] flush_pc_q, flush_pc_d;
   rob_entry_t head_e;
   logic [TAG_W-1:0] head_tag, shadow_tag, new_state;
   logic [IW-1:0] cdb_idx, q_i1, q_i2;
   logic disp_fire, cdb_hit, commit, head_wr, misp, clear_all;

   function automatic logic [32:0] query(input logic [TAG_W-1:0] tag, input logic busy, input logic ready,
                                         input logic [31:0] value, input logic cv, input logic [TAG_W-1:0] ct,
                                         input logic [31:0] cval);
      logic live;
      live = tag != NO_TAG && tag <= TAG_W'(DEPTH) && busy;
      if (live && cv && ct == tag) return {1'b1, cval};
      return (live && ready) ? {1'b1, value} : 33'd0;
   endfunction

   assign head_e     = ent_q[head_q];
   assign head_tag   = idx_to_tag(TAG_W'(head_q));
   assign disp_ready = !rst && !flush_pend_q && count_q < CW'(DEPTH);
   assign disp_tag   = disp_ready ? idx_to_tag(TAG_W'(tail_q)) : NO_TAG;
   assign disp_fire  = disp_valid && disp_ready && rdy;
   assign cdb_idx    = IW'(tag_to_idx(cdb_tag));
   assign cdb_hit    = cdb_valid && rdy && !flush_pend_q && cdb_tag != NO_TAG &&
                       cdb_tag <= TAG_W'(DEPTH) && ent_q[cdb_idx].busy;
   assign commit     = rdy && !flush_pend_q && count_q != '0 && head_e.busy && head_e.ready;
   assign head_wr    = commit && head_e.kind != T_STORE && head_e.rd != 5'd0;
   assign misp       = commit && head_e.kind == T_BRANCH && head_e.taken != head_e.pred;
   assign clear_all  = rdy && flush_pend_q;
   // a younger writer dispatched on the commit edge keeps the register renamed
   assign new_state  = (disp_fire && disp_rd == head_e.rd) ? disp_tag :
                       (shadow_tag == head_tag) ? NO_TAG : shadow_tag;

   rob_rename_table u_rename (
      .clk      (clk),
      .rst      (rst),
      .clr_all  (clear_all),
      .set_en   (disp_fire && disp_rd != 5'd0),
      .set_addr (disp_rd),
      .set_tag  (disp_tag),
      .clr_en   (head_wr),
      .clr_addr (head_e.rd),
      .clr_tag  (head_tag),
      .rd_addr  (head_e.rd),
      .rd_tag   (shadow_tag)
   );

   always_comb begin
      ent_d = ent_q;
      head_d = head_q;
      tail_d = tail_q;
      flush_pend_d = misp || (flush_pend_q && !rdy);
      if (disp_fire) begin
         ent_d[tail_q] = '{busy: 1'b1, ready: 1'b0, kind: rob_type_e'(disp_type), rd: disp_rd, pc: disp_pc,
                           pred: disp_pred_taken, value: 32'd0, taken: 1'b0, target: 32'd0};
         tail_d = (tail_q == IW'(DEPTH - 1)) ? '0 : tail_q + IW'(1);
      end
      if (cdb_hit) begin
         ent_d[cdb_idx].ready = 1'b1;
         ent_d[cdb_idx].value = cdb_value;
         ent_d[cdb_idx].taken = cdb_taken;
         ent_d[cdb_idx].target = cdb_target;
      end
      if (commit) begin
         ent_d[head_q].busy = 1'b0;
         head_d = (head_q == IW'(DEPTH - 1)) ? '0 : head_q + IW'(1);
      end
      count_d = count_q + CW'(disp_fire) - CW'(commit);
      if (clear_all) begin
         for (int i = 0; i < DEPTH; i++) ent_d[i].busy = 1'b0;
         head_d = '0;
         tail_d = '0;
         count_d = '0;
      end
   end

   always_comb begin
      we_d = head_wr;
      waddr_d = head_wr ? head_e.rd : 5'd0;
      wdata_d = head_wr ? {new_state, head_e.value} : 37'd0;
      store_d = commit && head_e.kind == T_STORE;
      flush_d = misp;
      flush_pc_d = misp ? (head_e.taken ? head_e.target : head_e.pc + 32'd4) : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
         flush_pend_q <= 1'b0;
         we_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         store_q <= 1'b0;
         flush_q <= 1'b0;
         flush_pc_q <= '0;
      end else begin
         ent_q <= ent_d;
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
         flush_pend_q <= flush_pend_d;
         we_q <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         store_q <= store_d;
         flush_q <= flush_d;
         flush_pc_q <= flush_pc_d;
      end
   end

   assign q_i1 = IW'(tag_to_idx(q_tag1));
   assign q_i2 = IW'(tag_to_idx(q_tag2));
   assign {q_ready1, q_value1} = query(q_tag1, ent_q[q_i1].busy, ent_q[q_i1].ready, ent_q[q_i1].value,
                                       cdb_valid, cdb_tag, cdb_value);
   assign {q_ready2, q_value2} = query(q_tag2, ent_q[q_i2].busy, ent_q[q_i2].ready, ent_q[q_i2].value,
                                       cdb_valid, cdb_tag, cdb_value);
   assign rf_write_enable = we_q;
   assign rf_write_addr   = waddr_q;
   assign rf_write_data   = wdata_q;
   assign store_commit    = store_q;
   assign flush           = flush_q;
   assign flush_pc        = flush_pc_q;
endmodule
